// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: frame FSM state codes,
// parity mode codes, divisor floor and the 3-sample majority helper.
package uart_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE     = 3'd0;
  localparam rx_state_t ST_START    = 3'd1;
  localparam rx_state_t ST_DATA     = 3'd2;
  localparam rx_state_t ST_PARITY   = 3'd3;
  localparam rx_state_t ST_STOP1    = 3'd4;
  localparam rx_state_t ST_STOP2    = 3'd5;
  localparam rx_state_t ST_BRK_WAIT = 3'd6;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_ODD   = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  localparam int MIN_CLKS_PER_BIT = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// First-word-fall-through receive FIFO. Head is visible whenever count is
// non-zero; head data reads as zero while empty. Push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_rx_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_n,
  input  logic                     i_Push,
  input  logic [WIDTH-1:0]         i_Data,
  output logic                     o_Full,
  input  logic                     i_Pop,
  output logic                     o_Valid,
  output logic [WIDTH-1:0]         o_Data,
  output logic [$clog2(DEPTH):0]   o_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign do_pop  = i_Pop && (count != '0);
  assign do_push = i_Push && ((count != FULL_CNT) || do_pop);

  assign o_Full  = (count == FULL_CNT);
  assign o_Valid = (count != '0);
  assign o_Data  = o_Valid ? mem[rd_ptr] : '0;
  assign o_Count = count;

  // storage array, written on accepted push only
  always_ff @(posedge i_Clock) begin
    if (do_push) mem[wr_ptr] <= i_Data;
  end

  // pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo_cfg.sv
// UART receiver with runtime divisor / parity / stop configuration,
// majority-vote sampling, parity/framing/break detection and an FWFT
// receive FIFO on the read side.
module uart_rx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic                          i_Rx_Serial,
  input  logic [DIV_W-1:0]              i_Clks_Per_Bit,
  input  logic [1:0]                    i_Parity_Mode,
  input  logic                          i_Two_Stop,
  input  logic                          i_Clear_Err,
  output logic                          o_Rx_Valid,
  input  logic                          i_Rx_Ready,
  output logic [DATA_BITS-1:0]          o_Rx_Data,
  output logic                          o_Rx_Parity_Err,
  output logic                          o_Rx_Frame_Err,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Overflow,
  output logic                          o_Break
);

  localparam int IW = $clog2(DATA_BITS);
  localparam int FW = DATA_BITS + 2;

  logic                 rx_s1, rx_s2;
  rx_state_t            state;
  logic [DIV_W-1:0]     cnt, cpb_q, half, cpb_eff;
  logic [1:0]           par_q;
  logic                 two_q;
  logic                 s_a, s_b;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_err_q, frm_err_q, par_bit_q;
  logic                 overflow_q, break_q;

  logic                 bit_end, at_dec, bit_val, par_on, fe_now;
  logic                 last_stop, brk_det, push;
  logic                 fifo_full, fifo_valid;
  logic [FW-1:0]        fifo_dout;

  assign cpb_eff = (i_Clks_Per_Bit < DIV_W'(MIN_CLKS_PER_BIT)) ?
                   DIV_W'(MIN_CLKS_PER_BIT) : i_Clks_Per_Bit;
  assign half    = cpb_q >> 1;
  assign bit_end = (cnt == cpb_q - 1'b1);
  assign at_dec  = (cnt == half + 1'b1);
  assign bit_val = maj3(s_a, s_b, rx_s2);
  assign par_on  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign fe_now  = frm_err_q | ~bit_val;

  // frame completion: break wins over a normal write on the first stop bit
  always_comb begin
    last_stop = 1'b0;
    brk_det   = 1'b0;
    if (at_dec) begin
      last_stop = ((state == ST_STOP1) && !two_q) || (state == ST_STOP2);
      brk_det   = (state == ST_STOP1) && !bit_val && (data_q == '0) &&
                  !(par_on && par_bit_q);
    end
    push = last_stop && !brk_det;
  end

  // two-flop synchroniser for the asynchronous line, idles high
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= i_Rx_Serial;
      rx_s2 <= rx_s1;
    end
  end

  // bit timer, sample capture and frame state machine
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cpb_q     <= DIV_W'(MIN_CLKS_PER_BIT);
      par_q     <= PAR_NONE;
      two_q     <= 1'b0;
      s_a       <= 1'b1;
      s_b       <= 1'b1;
      bit_idx   <= '0;
      data_q    <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
      if (cnt == half - 1'b1) s_a <= rx_s2;
      if (cnt == half)        s_b <= rx_s2;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s2) begin
            // configuration is frozen for the whole frame from here
            state     <= ST_START;
            cpb_q     <= cpb_eff;
            par_q     <= i_Parity_Mode;
            two_q     <= i_Two_Stop;
            bit_idx   <= '0;
            data_q    <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            par_bit_q <= 1'b0;
          end
        end
        ST_START: begin
          if (at_dec && bit_val) state <= ST_IDLE;
          else if (bit_end)      state <= ST_DATA;
        end
        ST_DATA: begin
          if (at_dec) data_q <= {bit_val, data_q[DATA_BITS-1:1]};
          if (bit_end) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IW'(DATA_BITS-1))
              state <= par_on ? ST_PARITY : ST_STOP1;
          end
        end
        ST_PARITY: begin
          if (at_dec) begin
            par_bit_q <= bit_val;
            par_err_q <= ((^data_q) ^ bit_val) != (par_q == PAR_ODD);
          end
          if (bit_end) state <= ST_STOP1;
        end
        ST_STOP1: begin
          if (at_dec) begin
            frm_err_q <= fe_now;
            if (brk_det)     state <= ST_BRK_WAIT;
            else if (!two_q) state <= ST_IDLE;
          end
          if (bit_end && two_q && !brk_det) state <= ST_STOP2;
        end
        ST_STOP2: begin
          if (at_dec) begin
            frm_err_q <= fe_now;
            state     <= ST_IDLE;
          end
        end
        ST_BRK_WAIT: begin
          cnt <= '0;
          if (rx_s2) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // sticky error flags, a new event beats a same-cycle clear
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      overflow_q <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      if (push && fifo_full && !(i_Rx_Ready && fifo_valid)) overflow_q <= 1'b1;
      else if (i_Clear_Err)                                 overflow_q <= 1'b0;
      if (brk_det)          break_q <= 1'b1;
      else if (i_Clear_Err) break_q <= 1'b0;
    end
  end

  uart_rx_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Push    (push),
    .i_Data    ({par_err_q, fe_now, data_q}),
    .o_Full    (fifo_full),
    .i_Pop     (i_Rx_Ready),
    .o_Valid   (fifo_valid),
    .o_Data    (fifo_dout),
    .o_Count   (o_Fifo_Count)
  );

  assign o_Rx_Valid      = fifo_valid;
  assign o_Rx_Data       = fifo_dout[DATA_BITS-1:0];
  assign o_Rx_Frame_Err  = fifo_dout[DATA_BITS];
  assign o_Rx_Parity_Err = fifo_dout[DATA_BITS+1];
  assign o_Overflow      = overflow_q;
  assign o_Break         = break_q;

endmodule

// File: tb/tb_uart_rx_fifo_cfg.sv
// Randomised bench: frames are built bit by bit on the pin, the expected
// word (or break / overflow) is computed from the frame contents and queued,
// and a negedge monitor checks every popped head word against that queue.
module tb_uart_rx_fifo_cfg;

  localparam int DB    = 8;
  localparam int DEPTH = 16;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [DW-1:0] cpb_in = 16'd16;
  logic [1:0]    pmode = 2'b00;
  logic          two = 1'b0;
  logic          clr = 1'b0;
  logic          ready = 1'b0;
  logic          o_Rx_Valid, o_Rx_Parity_Err, o_Rx_Frame_Err, o_Overflow, o_Break;
  logic [DB-1:0] o_Rx_Data;
  logic [$clog2(DEPTH):0] o_Fifo_Count;

  uart_rx_fifo_cfg #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
    .i_Clock         (clk),
    .i_Reset_n       (rst_n),
    .i_Rx_Serial     (rx),
    .i_Clks_Per_Bit  (cpb_in),
    .i_Parity_Mode   (pmode),
    .i_Two_Stop      (two),
    .i_Clear_Err     (clr),
    .o_Rx_Valid      (o_Rx_Valid),
    .i_Rx_Ready      (ready),
    .o_Rx_Data       (o_Rx_Data),
    .o_Rx_Parity_Err (o_Rx_Parity_Err),
    .o_Rx_Frame_Err  (o_Rx_Frame_Err),
    .o_Fifo_Count    (o_Fifo_Count),
    .o_Overflow      (o_Overflow),
    .o_Break         (o_Break)
  );

  always #5 clk = ~clk;

  typedef struct { logic pe; logic fe; logic [DB-1:0] d; } word_t;

  word_t expq[$];
  logic  exp_brk = 1'b0;
  logic  exp_ovf = 1'b0;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    rd_mode = 0;   // 0 hold, 1 random, 2 always
  int    start_cyc = 0;
  int    rise_cyc = -1;
  logic  mon_on = 1'b1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk); #1;
    ready = (rd_mode == 2) || ((rd_mode == 1) && ($urandom_range(1) == 1));
  end

  // head-of-FIFO monitor: every pop must match the next expected word
  initial begin
    logic  prev_v;
    word_t w;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && mon_on) begin
        if (o_Rx_Valid && !prev_v) rise_cyc = cyc;
        prev_v = o_Rx_Valid;
        if (o_Rx_Valid && ready) begin
          if (expq.size() == 0) chk("unexpected_word", 1, 0);
          else begin
            w = expq.pop_front();
            chk("pop_data", int'(o_Rx_Data), int'(w.d));
            chk("pop_perr", int'(o_Rx_Parity_Err), int'(w.pe));
            chk("pop_ferr", int'(o_Rx_Frame_Err), int'(w.fe));
          end
        end
      end else prev_v = 1'b0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drive one frame; the expected outcome is derived from the frame itself
  task automatic send(input logic [DB-1:0] d, input int cpb_raw, input logic [1:0] pm,
                      input logic tw, input logic bad_p, input logic s1, input logic s2);
    int    bt;
    logic  pon, p, brk;
    word_t w;
    bt  = (cpb_raw < 4) ? 4 : cpb_raw;
    pon = (pm == 2'b01) || (pm == 2'b10);
    p   = (^d) ^ (pm == 2'b10);
    if (bad_p) p = ~p;
    brk = (d == '0) && !(pon && p) && !s1;
    w.d  = d;
    w.pe = pon && bad_p;
    w.fe = !s1 || (tw && !s2);
    if (brk) exp_brk = 1'b1;
    else if (rd_mode == 0 && expq.size() >= DEPTH) exp_ovf = 1'b1;
    else expq.push_back(w);
    @(posedge clk); #1;
    cpb_in = DW'(cpb_raw); pmode = pm; two = tw;
    rx = 1'b0; start_cyc = cyc;
    cycles(bt);
    // scramble the live config: the frame in flight must not notice
    cpb_in = DW'($urandom_range(0, 40)); pmode = 2'($urandom_range(3)); two = 1'($urandom_range(1));
    for (int i = 0; i < DB; i++) begin rx = d[i]; cycles(bt); end
    if (pon) begin rx = p; cycles(bt); end
    rx = s1; cycles(bt);
    if (tw) begin rx = s2; cycles(bt); end
    rx = 1'b1;
    cycles(2 * bt + 4);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    repeat (3) @(negedge clk);
    chk({nm, "_drain"}, expq.size(), 0);
    chk({nm, "_count0"}, int'(o_Fifo_Count), 0);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
  endtask

  task automatic cfg16();
    cpb_in = 16'd16; pmode = 2'b00; two = 1'b0;
  endtask

  initial begin
    // reset state
    cycles(3);
    @(negedge clk);
    chk("rst_valid", int'(o_Rx_Valid), 0);
    chk("rst_count", int'(o_Fifo_Count), 0);
    chk("rst_data", int'(o_Rx_Data), 0);
    chk("rst_ovf", int'(o_Overflow), 0);
    chk("rst_brk", int'(o_Break), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    cycles(4);

    // 8N1 0xA5 at 16 clocks per bit, latency and head contents
    rd_mode = 0; rise_cyc = -1;
    send(8'hA5, 16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("t1_data", int'(o_Rx_Data), 'hA5);
    chk("t1_errs", int'({o_Rx_Parity_Err, o_Rx_Frame_Err}), 0);
    chk("t1_count", int'(o_Fifo_Count), 1);
    // stop-bit decision lands 9 bits + mid-bit after the start edge, plus sync
    chk("t1_latency_ok", int'((rise_cyc - start_cyc) >= 9*16 + 8 + 3 &&
                              (rise_cyc - start_cyc) <= 9*16 + 8 + 6), 1);
    rd_mode = 2; drain("t1");

    // parity even with a wrong bit, then odd with a correct bit
    rd_mode = 0;
    send(8'h07, 16, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2_even_perr", int'(o_Rx_Parity_Err), 1);
    chk("t2_even_data", int'(o_Rx_Data), 'h07);
    rd_mode = 2; drain("t2e");
    rd_mode = 0;
    send(8'h07, 16, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2_odd_perr", int'(o_Rx_Parity_Err), 0);
    rd_mode = 2; drain("t2o");

    // 8N2 with a low second stop bit, then a one-cycle idle glitch
    rd_mode = 0;
    send(8'h5A, 16, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t3_ferr", int'(o_Rx_Frame_Err), 1);
    chk("t3_data", int'(o_Rx_Data), 'h5A);
    rd_mode = 2; drain("t3");
    cfg16();
    @(posedge clk); #1; rx = 1'b0;
    @(posedge clk); #1; rx = 1'b1;
    cycles(60);
    @(negedge clk);
    chk("t3_glitch_count", int'(o_Fifo_Count), 0);

    // line held low for 12 bit times, then a clean frame
    rd_mode = 0; cfg16();
    rx = 1'b0; cycles(12 * 16); rx = 1'b1; cycles(40);
    exp_brk = 1'b1;
    @(negedge clk);
    chk("t4_break", int'(o_Break), 1);
    chk("t4_count", int'(o_Fifo_Count), 0);
    send(8'h3C, 16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("t4_data", int'(o_Rx_Data), 'h3C);
    chk("t4_errs", int'({o_Rx_Parity_Err, o_Rx_Frame_Err}), 0);
    chk("t4_count1", int'(o_Fifo_Count), 1);

    // reset in the middle of the data bits with a word held and break set
    cfg16();
    rx = 1'b0; cycles(3 * 16);
    rst_n = 1'b0; rx = 1'b1;
    cycles(2);
    expq.delete(); exp_brk = 1'b0; exp_ovf = 1'b0;
    @(negedge clk);
    chk("t6_valid", int'(o_Rx_Valid), 0);
    chk("t6_count", int'(o_Fifo_Count), 0);
    chk("t6_brk", int'(o_Break), 0);
    chk("t6_data", int'(o_Rx_Data), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    cycles(12 * 16);
    @(negedge clk);
    chk("t6_no_write", int'(o_Fifo_Count), 0);

    // 17 frames into a 16-deep FIFO with the consumer stalled
    rd_mode = 0;
    for (int i = 0; i < 17; i++)
      send(8'($urandom), $urandom_range(4, 8), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("t5_count", int'(o_Fifo_Count), 16);
    chk("t5_ovf", int'(o_Overflow), int'(exp_ovf));
    chk("t5_model_ovf", int'(exp_ovf), 1);
    rd_mode = 2; drain("t5");
    pulse_clear(); exp_ovf = 1'b0;
    @(negedge clk);
    chk("t5_ovf_clear", int'(o_Overflow), 0);

    // randomised frames with random configuration and consumer stalls
    rd_mode = 1;
    for (int i = 0; i < 60; i++) begin
      logic [DB-1:0] d;
      d = ($urandom_range(7) == 0) ? '0 : DB'($urandom);
      send(d, $urandom_range(2, 20), 2'($urandom_range(3)), 1'($urandom_range(1)),
           1'($urandom_range(1)), ($urandom_range(5) != 0), ($urandom_range(5) != 0));
      drain("rnd");
      @(negedge clk);
      chk("rnd_brk", int'(o_Break), int'(exp_brk));
      chk("rnd_ovf", int'(o_Overflow), int'(exp_ovf));
      if (exp_brk) begin pulse_clear(); exp_brk = 1'b0; end
    end

    rd_mode = 0;
    cycles(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
